object_plotter: RTL and testbench
=================================

Name: object_plotter

Overview:
- Sits directly downstream of the game-logic controller.
- Consumes each one-cycle startPlot request with its rectangle descriptor (newX/newY/oldX/oldY/sizeX/sizeY/object) and rasterises it into single-pixel writes for the VGA adapter, one pixel per clock.
- For moving objects it erases the old rectangle, then draws the new one.
- For image objects it fetches pixel colours from an external image ROM through a one-cycle-latency read port.

Parameters:
- MAX_X, 159, rightmost visible column; pixels with x > MAX_X are suppressed.
- MAX_Y, 119, bottom visible row; pixels with y > MAX_Y are suppressed.
- IMG_W, 140, image ROM row width in pixels.
- BALL_COLOUR, 3'b111, ball fill colour.
- PADDLE_COLOUR, 3'b010, paddle fill colour.
- BLOCK_COLOUR, 3'b100, brick interior colour.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startPlot  in  1  request strobe; sampled only in IDLE
- object  in  3  0 ball, 1 paddle, 2 block, 3 noObj, 4 startImg, 5 gameOver, 6-7 reserved
- newX  in  8  new rectangle left edge
- newY  in  7  new rectangle top edge
- oldX  in  8  previous rectangle left edge (erase source)
- oldY  in  7  previous rectangle top edge (erase source)
- sizeX  in  8  rectangle width, 0..160
- sizeY  in  7  rectangle height, 0..120
- img_addr  out  14  ROM address = row*IMG_W + col
- img_sel  out  1  0 start image, 1 game-over image
- img_q  in  3  ROM colour, valid one cycle after img_addr
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write enable
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle pulse when a request completes

Behaviour:
- Reset values: all outputs 0; state IDLE; pipeline valid bit cleared.
- Reset mid-operation: the request is abandoned; vga_plot is 0 from the next cycle; no done pulse.
- Capture: in IDLE with startPlot=1, all descriptor inputs are registered at that edge. startPlot while busy=1 is ignored; the request is lost.
- States: IDLE -> ERASE (ball/paddle only) -> DRAW -> FLUSH -> IDLE.
- Entry from IDLE:
  - Ball/paddle go to ERASE, unless oldX==newX and oldY==newY, in which case they go to DRAW.
  - Codes 2-5 go to DRAW.
  - Codes 6-7, sizeX==0 or sizeY==0 go to FLUSH; no pixels are written.
- Scan order:
  - Local col c = 0..sizeX-1 is the inner loop; local row r = 0..sizeY-1 is the outer loop.
  - One coordinate is issued per cycle. ERASE uses the old origin; DRAW uses the new origin.
  - After the last pixel of ERASE, DRAW starts at (0,0) the next cycle with no gap.
- Pipeline:
  - Stage 0 issues coordinate and img_addr; stage 1 registers vga_x/vga_y/vga_colour/vga_plot.
  - First vga_plot occurs 2 edges after the capture edge.
  - Latency is uniform for all objects, so ROM data aligns with its pixel.
- Colours:
  - ERASE: 000.
  - Ball: BALL_COLOUR. Paddle: PADDLE_COLOUR. noObj: 000.
  - Block: 000 when c==0, c==sizeX-1, r==0 or r==sizeY-1; otherwise BLOCK_COLOUR.
  - startImg/gameOver: img_q; img_sel = (object==5); img_addr = r*IMG_W + c.
- Arithmetic and clipping:
  - Absolute x = origin + c, computed 9 bits wide; absolute y computed 8 bits wide; no wraparound.
  - If x > MAX_X or y > MAX_Y, vga_plot=0 for that slot, but the slot still consumes a cycle.
- Timing:
  - busy goes high the edge after capture and stays high through the cycle the last pixel is on the outputs.
  - FLUSH lasts one cycle with done=1; busy=0 when returning to IDLE.
  - Total request length is (erase pixels + draw pixels + 2) cycles from the capture edge to the done pulse.
- Full screen clear (160x120, noObj) takes 19202 cycles, inside the 50000-cycle window the controller allows.

Test Plan:
- Ball move: object=0, old (51,112), new (52,111), size 4x4.
  -> 16 erase writes of colour 000 covering x51-54/y112-115, then 16 writes of 111 covering x52-55/y111-114.
  -> First write 2 cycles after capture; done at cycle 34.
- Paddle stationary: old=new=(69,117), size 20x1.
  -> No erase; 20 writes of 010 on y=117, x69-88; done at cycle 22.
- Block at (16,8), size 16x8.
  -> 128 writes; pixel (16,8) is 000, (17,9) is 100, (31,15) is 000.
- Start image at (9,40), 140x70; bench ROM returns addr[2:0].
  -> Pixel (x,y) colour = ((y-40)*140 + (x-9))[2:0]; last img_addr is 9799; img_sel=0.
- Clipping and degenerate sizes:
  - Ball at new (158,118), size 4x4 -> only (158,118), (159,118), (158,119), (159,119) plotted.
  - sizeX=0 -> zero writes, done 2 cycles after capture.
  - Object code 7 -> zero writes.
- Busy and reset:
  - Second startPlot during a 160x120 clear -> ignored; exactly 19200 writes.
  - reset asserted at cycle 100 -> vga_plot=0 and busy=0 from the next cycle; no done pulse.

Source files
------------

// File: rtl/object_plotter.sv
// rtl/object_plotter.sv - rasterises rectangle requests into single-pixel VGA writes
// Two-stage pipeline: stage 0 issues coordinate and ROM address, stage 1 drives the VGA write.
module object_plotter #(
  parameter int MAX_X = 159,
  parameter int MAX_Y = 119,
  parameter int IMG_W = 140,
  parameter logic [2:0] BALL_COLOUR = 3'b111,
  parameter logic [2:0] PADDLE_COLOUR = 3'b010,
  parameter logic [2:0] BLOCK_COLOUR = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startPlot,
  input  logic [2:0]  object,
  input  logic [7:0]  newX,
  input  logic [6:0]  newY,
  input  logic [7:0]  oldX,
  input  logic [6:0]  oldY,
  input  logic [7:0]  sizeX,
  input  logic [6:0]  sizeY,
  output logic [13:0] img_addr,
  output logic        img_sel,
  input  logic [2:0]  img_q,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FLUSH} state_t;

  localparam logic [13:0] IMG_W14 = 14'(IMG_W);

  state_t     state, state_next;
  logic [7:0] col, col_next;
  logic [6:0] row, row_next;
  logic       capture;

  logic [2:0] obj_r;
  logic [7:0] new_x_r, old_x_r, size_x_r;
  logic [6:0] new_y_r, old_y_r, size_y_r;

  logic       issue, in_view, border, use_img;
  logic [7:0] org_x;
  logic [6:0] org_y;
  logic [8:0] abs_x;
  logic [7:0] abs_y;
  logic [2:0] fixed_colour;

  logic       p_valid, p_in_view, p_img, p_done;
  logic [7:0] p_x;
  logic [6:0] p_y;
  logic [2:0] p_colour;

  // busy also covers the drain cycle after FLUSH, so a request cannot overlap the tail
  assign capture = (state == IDLE) && startPlot && !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      row   <= row_next;
    end
  end

  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    case (state)
      IDLE: begin
        if (capture) begin
          col_next = '0;
          row_next = '0;
          if (object > 3'd5 || sizeX == 8'd0 || sizeY == 7'd0)
            state_next = FLUSH;
          else if (object <= 3'd1 && (oldX != newX || oldY != newY))
            state_next = ERASE;
          else
            state_next = DRAW;
        end
      end
      ERASE, DRAW: begin
        if (col == size_x_r - 8'd1) begin
          col_next = '0;
          if (row == size_y_r - 7'd1) begin
            row_next   = '0;
            state_next = (state == ERASE) ? DRAW : FLUSH;
          end else begin
            row_next = row + 7'd1;
          end
        end else begin
          col_next = col + 8'd1;
        end
      end
      FLUSH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      obj_r    <= '0;
      new_x_r  <= '0;
      new_y_r  <= '0;
      old_x_r  <= '0;
      old_y_r  <= '0;
      size_x_r <= '0;
      size_y_r <= '0;
    end else if (capture) begin
      obj_r    <= object;
      new_x_r  <= newX;
      new_y_r  <= newY;
      old_x_r  <= oldX;
      old_y_r  <= oldY;
      size_x_r <= sizeX;
      size_y_r <= sizeY;
    end
  end

  always_comb begin
    issue   = (state == ERASE) || (state == DRAW);
    org_x   = (state == ERASE) ? old_x_r : new_x_r;
    org_y   = (state == ERASE) ? old_y_r : new_y_r;
    abs_x   = {1'b0, org_x} + {1'b0, col};
    abs_y   = {1'b0, org_y} + {1'b0, row};
    in_view = (abs_x <= 9'(MAX_X)) && (abs_y <= 8'(MAX_Y));
    border  = (col == 8'd0) || (col == size_x_r - 8'd1) ||
              (row == 7'd0) || (row == size_y_r - 7'd1);
    use_img = (state == DRAW) && (obj_r == 3'd4 || obj_r == 3'd5);
    fixed_colour = 3'b000;
    if (state == DRAW) begin
      case (obj_r)
        3'd0:    fixed_colour = BALL_COLOUR;
        3'd1:    fixed_colour = PADDLE_COLOUR;
        3'd2:    fixed_colour = border ? 3'b000 : BLOCK_COLOUR;
        default: fixed_colour = 3'b000;
      endcase
    end
  end

  // ROM address leaves straight from the counters so its data lands with stage 1
  assign img_addr = 14'(row) * IMG_W14 + 14'(col);
  assign img_sel  = (obj_r == 3'd5);

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid    <= 1'b0;
      p_in_view  <= 1'b0;
      p_img      <= 1'b0;
      p_done     <= 1'b0;
      p_x        <= '0;
      p_y        <= '0;
      p_colour   <= '0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      p_valid    <= issue;
      p_in_view  <= in_view;
      p_img      <= use_img;
      p_done     <= (state == FLUSH);
      p_x        <= abs_x[7:0];
      p_y        <= abs_y[6:0];
      p_colour   <= fixed_colour;
      vga_plot   <= p_valid && p_in_view;
      vga_x      <= p_x;
      vga_y      <= p_y;
      vga_colour <= p_img ? img_q : p_colour;
      done       <= p_done;
      busy       <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_object_plotter.sv
// tb/tb_object_plotter.sv - directed self-checking bench for object_plotter
// ROM model returns the low three address bits, one cycle after the address.
module tb_object_plotter;

  logic        clk = 1'b0;
  logic        reset, startPlot;
  logic [2:0]  object;
  logic [7:0]  newX, oldX, sizeX;
  logic [6:0]  newY, oldY, sizeY;
  logic [13:0] img_addr;
  logic        img_sel;
  logic [2:0]  img_q;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, done;

  int errors = 0;
  int checks = 0;

  int writes, first_w, done_cyc, img_err, max_addr, done_seen;
  int cnt_col [8];
  int minx [8], maxx [8], miny [8], maxy [8];
  logic [2:0] frame [160][120];
  logic [2:0] first_col;
  logic       busy1, busy_done, sel1;

  object_plotter dut (
    .clk(clk), .reset(reset), .startPlot(startPlot), .object(object),
    .newX(newX), .newY(newY), .oldX(oldX), .oldY(oldY),
    .sizeX(sizeX), .sizeY(sizeY), .img_addr(img_addr), .img_sel(img_sel),
    .img_q(img_q), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) img_q <= img_addr[2:0];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one request and records every write until done or the cycle limit.
  // Cycle k is sampled #1 after the k-th edge following the capture edge.
  task automatic run_req(input logic [2:0] ob, input logic [7:0] nx, input logic [6:0] ny,
                         input logic [7:0] ox, input logic [6:0] oy,
                         input logic [7:0] sx, input logic [6:0] sy,
                         input int limit, input int poke);
    int dx, dy, e;
    writes = 0; first_w = -1; done_cyc = -1; img_err = 0; max_addr = 0;
    first_col = 3'd0; busy1 = 1'b0; busy_done = 1'b1; sel1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cnt_col[i] = 0; minx[i] = 999; maxx[i] = -1; miny[i] = 999; maxy[i] = -1;
    end
    @(negedge clk);
    object = ob; newX = nx; newY = ny; oldX = ox; oldY = oy; sizeX = sx; sizeY = sy;
    startPlot = 1'b1;
    @(posedge clk);
    #1 startPlot = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        busy1 = busy;
        sel1  = img_sel;
      end
      if (int'(img_addr) > max_addr) max_addr = int'(img_addr);
      if (vga_plot === 1'b1) begin
        writes++;
        if (first_w < 0) begin
          first_w   = k;
          first_col = vga_colour;
        end
        cnt_col[vga_colour]++;
        if (int'(vga_x) < minx[vga_colour]) minx[vga_colour] = int'(vga_x);
        if (int'(vga_x) > maxx[vga_colour]) maxx[vga_colour] = int'(vga_x);
        if (int'(vga_y) < miny[vga_colour]) miny[vga_colour] = int'(vga_y);
        if (int'(vga_y) > maxy[vga_colour]) maxy[vga_colour] = int'(vga_y);
        if (vga_x < 8'd160 && vga_y < 7'd120) frame[vga_x][vga_y] = vga_colour;
        if (ob >= 3'd4) begin
          dx = int'(vga_x) - int'(nx);
          dy = int'(vga_y) - int'(ny);
          e  = (dy * 140 + dx) & 7;
          if (int'(vga_colour) != e) img_err++;
        end
      end
      if (k == poke) begin
        object = 3'd0;
        startPlot = 1'b1;
      end else begin
        startPlot = 1'b0;
      end
      if (done === 1'b1) begin
        done_cyc  = k;
        busy_done = busy;
        break;
      end
    end
    startPlot = 1'b0;
  endtask

  initial begin
    reset = 1'b1; startPlot = 1'b0; object = '0;
    newX = '0; newY = '0; oldX = '0; oldY = '0; sizeX = '0; sizeY = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_plot", int'(vga_plot), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_xy", int'({vga_x, vga_y, vga_colour}), 0);
    check("reset_addr", int'({img_addr, img_sel}), 0);
    @(negedge clk);
    reset = 1'b0;

    run_req(3'd0, 8'd52, 7'd111, 8'd51, 7'd112, 8'd4, 7'd4, 60, -1);
    check("ball_writes", writes, 32);
    check("ball_first_cycle", first_w, 2);
    check("ball_first_colour", int'(first_col), 0);
    check("ball_done_cycle", done_cyc, 34);
    check("ball_busy_c1", int'(busy1), 1);
    check("ball_busy_done", int'(busy_done), 0);
    check("ball_erase_cnt", cnt_col[0], 16);
    check("ball_draw_cnt", cnt_col[7], 16);
    check("ball_erase_box", minx[0] * 1000000 + maxx[0] * 10000 + miny[0] * 100 + maxy[0],
          51 * 1000000 + 54 * 10000 + 112 * 100 + 115);
    check("ball_draw_box", minx[7] * 1000000 + maxx[7] * 10000 + miny[7] * 100 + maxy[7],
          52 * 1000000 + 55 * 10000 + 111 * 100 + 114);

    run_req(3'd1, 8'd69, 7'd117, 8'd69, 7'd117, 8'd20, 7'd1, 60, -1);
    check("paddle_writes", writes, 20);
    check("paddle_colour_cnt", cnt_col[2], 20);
    check("paddle_done_cycle", done_cyc, 22);
    check("paddle_box", minx[2] * 1000000 + maxx[2] * 10000 + miny[2] * 100 + maxy[2],
          69 * 1000000 + 88 * 10000 + 117 * 100 + 117);

    run_req(3'd2, 8'd16, 7'd8, 8'd0, 7'd0, 8'd16, 7'd8, 200, -1);
    check("block_writes", writes, 128);
    check("block_done_cycle", done_cyc, 130);
    check("block_corner", int'(frame[16][8]), 0);
    check("block_inner", int'(frame[17][9]), 4);
    check("block_far_corner", int'(frame[31][15]), 0);
    check("block_inner_cnt", cnt_col[4], 84);

    run_req(3'd4, 8'd9, 7'd40, 8'd9, 7'd40, 8'd140, 7'd70, 9900, -1);
    check("img_writes", writes, 9800);
    check("img_colour_errs", img_err, 0);
    check("img_last_addr", max_addr, 9799);
    check("img_sel", int'(sel1), 0);
    check("img_done_cycle", done_cyc, 9802);

    run_req(3'd0, 8'd158, 7'd118, 8'd158, 7'd118, 8'd4, 7'd4, 60, -1);
    check("clip_writes", writes, 4);
    check("clip_box", minx[7] * 1000000 + maxx[7] * 10000 + miny[7] * 100 + maxy[7],
          158 * 1000000 + 159 * 10000 + 118 * 100 + 119);
    check("clip_done_cycle", done_cyc, 18);

    run_req(3'd0, 8'd10, 7'd10, 8'd20, 7'd20, 8'd0, 7'd5, 20, -1);
    check("zero_w_writes", writes, 0);
    check("zero_w_done_cycle", done_cyc, 2);

    run_req(3'd7, 8'd10, 7'd10, 8'd10, 7'd10, 8'd4, 7'd4, 20, -1);
    check("code7_writes", writes, 0);
    check("code7_done_cycle", done_cyc, 2);

    run_req(3'd3, 8'd0, 7'd0, 8'd0, 7'd0, 8'd160, 7'd120, 19300, 500);
    check("clear_writes", writes, 19200);
    check("clear_black_cnt", cnt_col[0], 19200);
    check("clear_done_cycle", done_cyc, 19202);

    run_req(3'd3, 8'd0, 7'd0, 8'd0, 7'd0, 8'd160, 7'd120, 100, -1);
    check("rst_pre_writes", writes, 99);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_plot", int'(vga_plot), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || vga_plot === 1'b1) done_seen++;
    end
    check("rst_no_done", done_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
